// File: rtl/keypad_code_entry.sv
// Keypad code entry: collects NUM_DIGITS decimal digits into a 16-bit binary code
// and presents it to the parking controller until acknowledged.
// Optional inter-digit timeout is enabled by defining KEYPAD_TIMEOUT_EN.
module keypad_code_entry #(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_clear,
  input  logic        code_ack,
  output logic [15:0] code,
  output logic        code_valid,
  output logic        busy,
  output logic [2:0]  digit_count,
  output logic        key_error
);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_bad_num_digits
      $error("keypad_code_entry: NUM_DIGITS must be 1..4");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("keypad_code_entry: TIMEOUT_CYCLES must be 1..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [2:0] LAST_COUNT = 3'(NUM_DIGITS);

  state_t      state_q;
  logic [15:0] acc_q;
  logic [15:0] code_q;
  logic        code_valid_q;
  logic        busy_q;
  logic [2:0]  digit_count_q;
  logic        key_error_q;

  logic        digit_ok;
  logic [15:0] acc_d;
  logic [2:0]  count_d;
  logic        last_digit;

  assign digit_ok   = (key_digit <= 4'd9);
  assign acc_d      = 16'(acc_q * 16'd10) + {12'd0, key_digit};
  assign count_d    = digit_count_q + 3'd1;
  assign last_digit = (count_d == LAST_COUNT);

`ifdef KEYPAD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      code_q        <= '0;
      code_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      digit_count_q <= '0;
      key_error_q   <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      key_error_q <= 1'b0;
      // Clear wins over anything else arriving in the same cycle, including ack.
      if (key_clear) begin
        state_q       <= IDLE;
        acc_q         <= '0;
        code_valid_q  <= 1'b0;
        busy_q        <= 1'b0;
        digit_count_q <= '0;
`ifdef KEYPAD_TIMEOUT_EN
        tmo_q         <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (key_valid) begin
              if (digit_ok) begin
                acc_q         <= {12'd0, key_digit};
                digit_count_q <= 3'd1;
                busy_q        <= 1'b1;
`ifdef KEYPAD_TIMEOUT_EN
                tmo_q         <= '0;
`endif
                if (NUM_DIGITS == 1) begin
                  state_q      <= PRESENT;
                  code_q       <= {12'd0, key_digit};
                  code_valid_q <= 1'b1;
                end else begin
                  state_q <= COLLECT;
                end
              end else begin
                key_error_q   <= 1'b1;
                acc_q         <= '0;
                digit_count_q <= '0;
              end
            end
          end

          COLLECT: begin
            if (key_valid) begin
              if (digit_ok) begin
                acc_q         <= acc_d;
                digit_count_q <= count_d;
`ifdef KEYPAD_TIMEOUT_EN
                tmo_q         <= '0;
`endif
                if (last_digit) begin
                  state_q      <= PRESENT;
                  code_q       <= acc_d;
                  code_valid_q <= 1'b1;
                end
              end else begin
                key_error_q   <= 1'b1;
                state_q       <= IDLE;
                busy_q        <= 1'b0;
                acc_q         <= '0;
                digit_count_q <= '0;
              end
            end
`ifdef KEYPAD_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
              key_error_q   <= 1'b1;
              state_q       <= IDLE;
              busy_q        <= 1'b0;
              acc_q         <= '0;
              digit_count_q <= '0;
              tmo_q         <= '0;
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
`endif
          end

          PRESENT: begin
            // Held digits are frozen here; only an ack releases the code.
            if (code_ack) begin
              state_q       <= IDLE;
              code_valid_q  <= 1'b0;
              busy_q        <= 1'b0;
              acc_q         <= '0;
              digit_count_q <= '0;
            end
          end

          default: begin
            state_q       <= IDLE;
            code_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            acc_q         <= '0;
            digit_count_q <= '0;
          end
        endcase
      end
    end
  end

  assign code        = code_q;
  assign code_valid  = code_valid_q;
  assign busy        = busy_q;
  assign digit_count = digit_count_q;
  assign key_error   = key_error_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Self-checking bench for keypad_code_entry: directed vector table, hand-written
// reset/timeout sequences, then random traffic against a digit-queue reference model.
module tb_keypad_code_entry;

  localparam int ND  = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        key_clear = 1'b0;
  logic        code_ack = 1'b0;
  logic [15:0] code;
  logic        code_valid;
  logic        busy;
  logic [2:0]  digit_count;
  logic        key_error;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  keypad_code_entry #(
    .NUM_DIGITS    (ND),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .key_clear  (key_clear),
    .code_ack   (code_ack),
    .code       (code),
    .code_valid (code_valid),
    .busy       (busy),
    .digit_count(digit_count),
    .key_error  (key_error)
  );

  typedef struct {
    logic        v;
    logic [3:0]  d;
    logic        c;
    logic        a;
    logic [15:0] code;
    logic        cv;
    logic        busy;
    logic [2:0]  cnt;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [3:0] d, input logic c, input logic a,
                     input logic [15:0] e_code, input logic e_cv, input logic e_busy,
                     input logic [2:0] e_cnt, input logic e_err);
    vec_t t;
    t.v = v; t.d = d; t.c = c; t.a = a;
    t.code = e_code; t.cv = e_cv; t.busy = e_busy; t.cnt = e_cnt; t.err = e_err;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [15:0] e_code, input logic e_cv,
                       input logic e_busy, input logic [2:0] e_cnt, input logic e_err);
    vectors++;
    if ({code, code_valid, busy, digit_count, key_error} !== {e_code, e_cv, e_busy, e_cnt, e_err}) begin
      miscompares++;
      $display("FAIL %s: got code=%0d cv=%b busy=%b cnt=%0d err=%b, want code=%0d cv=%b busy=%b cnt=%0d err=%b",
               name, code, code_valid, busy, digit_count, key_error, e_code, e_cv, e_busy, e_cnt, e_err);
    end else begin
      $display("ok   %s: code=%0d cv=%b busy=%b cnt=%0d err=%b",
               name, code, code_valid, busy, digit_count, key_error);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic v, input logic [3:0] d, input logic c, input logic a);
    key_valid = v;
    key_digit = d;
    key_clear = c;
    code_ack  = a;
    @(posedge clk);
    #1;
  endtask

  // Reference model state: digits entered so far, whether a code is being presented.
  int  m_digits[$];
  bit  m_present;
  int  m_code;
  int  m_idle;
  bit  m_err;

  function automatic int digits_value();
    int val = 0;
    for (int k = 0; k < m_digits.size(); k++) begin
      int p = 1;
      for (int j = 0; j < m_digits.size() - 1 - k; j++) p = p * 10;
      val = val + m_digits[k] * p;
    end
    return val;
  endfunction

  task automatic model_cycle(input bit v, input int d, input bit c, input bit a);
    m_err = 1'b0;
    if (c) begin
      m_digits.delete();
      m_present = 1'b0;
    end else if (m_present) begin
      if (a) begin
        m_present = 1'b0;
        m_digits.delete();
      end
    end else if (v) begin
      if (d > 9) begin
        m_err = 1'b1;
        m_digits.delete();
      end else begin
        m_digits.push_back(d);
        m_idle = 0;
        if (m_digits.size() == ND) begin
          m_code    = digits_value();
          m_present = 1'b1;
        end
      end
    end else if (m_digits.size() > 0) begin
`ifdef KEYPAD_TIMEOUT_EN
      m_idle++;
      if (m_idle == TMO) begin
        m_err = 1'b1;
        m_digits.delete();
      end
`endif
    end
  endtask

  initial begin
    // Directed table: {v, d, clear, ack} -> {code, cv, busy, cnt, err}
    add(1, 5, 0, 0,    0, 0, 1, 1, 0);
    add(1, 9, 0, 0,    0, 0, 1, 2, 0);
    add(1, 9, 0, 0,    0, 0, 1, 3, 0);
    add(1, 0, 0, 0, 5990, 1, 1, 4, 0);
    add(0, 0, 0, 0, 5990, 1, 1, 4, 0);
    add(1, 1, 0, 0, 5990, 1, 1, 4, 0);
    add(1, 1, 0, 0, 5990, 1, 1, 4, 0);
    add(0, 0, 0, 1, 5990, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5990, 0, 0, 0, 0);
    add(0, 0, 0, 1, 5990, 0, 0, 0, 0);
    add(1, 1, 0, 0, 5990, 0, 1, 1, 0);
    add(1, 2, 0, 0, 5990, 0, 1, 2, 0);
    add(1, 10, 0, 0, 5990, 0, 0, 0, 1);
    add(0, 0, 0, 0, 5990, 0, 0, 0, 0);
    add(1, 3, 0, 0, 5990, 0, 1, 1, 0);
    add(1, 4, 0, 0, 5990, 0, 1, 2, 0);
    add(1, 7, 1, 0, 5990, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5990, 0, 0, 0, 0);
    add(1, 15, 0, 0, 5990, 0, 0, 0, 1);
    add(0, 0, 0, 0, 5990, 0, 0, 0, 0);
    add(1, 1, 0, 0, 5990, 0, 1, 1, 0);
    add(1, 2, 0, 0, 5990, 0, 1, 2, 0);
    add(1, 3, 0, 0, 5990, 0, 1, 3, 0);
    add(1, 4, 0, 0, 1234, 1, 1, 4, 0);
    add(0, 0, 1, 1, 1234, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1234, 0, 1, 1, 0);
    add(1, 0, 0, 0, 1234, 0, 1, 2, 0);
    add(1, 0, 0, 0, 1234, 0, 1, 3, 0);
    add(1, 7, 0, 0,    7, 1, 1, 4, 0);
    add(0, 0, 1, 0,    7, 0, 0, 0, 0);
    add(1, 9, 0, 0,    7, 0, 1, 1, 0);
    add(1, 9, 0, 0,    7, 0, 1, 2, 0);
    add(1, 9, 0, 0,    7, 0, 1, 3, 0);
    add(1, 9, 0, 0, 9999, 1, 1, 4, 0);
    add(0, 0, 0, 1, 9999, 0, 0, 0, 0);

    rst = 1'b0;
    #3;
    check("reset_async", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 0, 0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].a);
      check($sformatf("tbl%0d", i), tbl[i].code, tbl[i].cv, tbl[i].busy, tbl[i].cnt, tbl[i].err);
    end

    // Reset mid-entry: outputs must drop without a clock edge.
    step(1, 1, 0, 0); check("mid1", 9999, 0, 1, 1, 0);
    step(1, 2, 0, 0); check("mid2", 9999, 0, 1, 2, 0);
    step(1, 3, 0, 0); check("mid3", 9999, 0, 1, 3, 0);
    key_valid = 1'b0;
    #1 rst = 1'b0;
    #1 check("rst_midcycle", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    step(1, 5, 0, 0); check("fresh1", 0, 0, 1, 1, 0);
    step(1, 9, 0, 0); check("fresh2", 0, 0, 1, 2, 0);
    step(1, 9, 0, 0); check("fresh3", 0, 0, 1, 3, 0);
    step(1, 0, 0, 0); check("fresh4", 5990, 1, 1, 4, 0);
    step(0, 0, 0, 1); check("fresh_ack", 5990, 0, 0, 0, 0);

    // Inter-digit idle period of exactly TMO cycles.
    step(1, 6, 0, 0); check("tmo_digit", 5990, 0, 1, 1, 0);
    for (int k = 1; k <= TMO; k++) begin
`ifdef KEYPAD_TIMEOUT_EN
      step(0, 0, 0, 0);
      if (k == TMO) check($sformatf("tmo_idle%0d", k), 5990, 0, 0, 0, 1);
      else          check($sformatf("tmo_idle%0d", k), 5990, 0, 1, 1, 0);
`else
      step(0, 0, 0, 0);
      check($sformatf("tmo_idle%0d", k), 5990, 0, 1, 1, 0);
`endif
    end
    step(0, 0, 1, 0); check("tmo_clear", 5990, 0, 0, 0, 0);

    // Accepted digits restart the idle count.
    step(1, 2, 0, 0); check("tmo_rst_d1", 5990, 0, 1, 1, 0);
    for (int k = 1; k < TMO; k++) step(0, 0, 0, 0);
    check("tmo_rst_gap1", 5990, 0, 1, 1, 0);
    step(1, 3, 0, 0); check("tmo_rst_d2", 5990, 0, 1, 2, 0);
    for (int k = 1; k < TMO; k++) step(0, 0, 0, 0);
    check("tmo_rst_gap2", 5990, 0, 1, 2, 0);
    step(0, 0, 1, 0); check("tmo_rst_clear", 5990, 0, 0, 0, 0);

    // Random traffic against the reference model, starting from IDLE.
    m_digits.delete();
    m_present = 1'b0;
    m_code    = 5990;
    m_idle    = 0;
    for (int i = 0; i < 800; i++) begin
      bit v, c, a;
      int d;
      v = ($urandom_range(0, 99) < (((i % 100) < 75) ? 45 : 4));
      d = ($urandom_range(0, 99) < 8) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      c = ($urandom_range(0, 99) < 3);
      a = ($urandom_range(0, 99) < 20);
      model_cycle(v, d, c, a);
      step(v, 4'(d), c, a);
      check($sformatf("rnd%0d v=%0d d=%0d c=%0d a=%0d", i, v, d, c, a),
            16'(m_code), m_present, (m_present || m_digits.size() > 0),
            3'(m_digits.size()), m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_code_entry.md
KEYPAD_CODE_ENTRY -- requirements
Module: keypad_code_entry

Interface
REQ-001 Parameter NUM_DIGITS, default 4, decimal digits per code; legal range 1..4.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, idle cycles allowed between digits; legal range 1..65535.
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port key_valid  input  1  one-cycle strobe, key_digit valid.
REQ-006 Port key_digit  input  4  keypad digit, legal 0..9.
REQ-007 Port key_clear  input  1  abort current entry.
REQ-008 Port code_ack  input  1  parking controller has consumed code.
REQ-009 Port code  output  16  binary value of entered decimal code, to controller code input.
REQ-010 Port code_valid  output  1  code holds a complete entry awaiting code_ack.
REQ-011 Port busy  output  1  high whenever state is not IDLE.
REQ-012 Port digit_count  output  3  digits accepted in current entry.
REQ-013 Port key_error  output  1  one-cycle pulse on rejected entry.

Function
REQ-014 FSM states SHALL be IDLE, COLLECT, PRESENT; all outputs registered.
REQ-015 IDLE: key_valid with key_digit<=9 SHALL load acc=key_digit, digit_count=1, go to COLLECT (PRESENT if NUM_DIGITS=1).
REQ-016 COLLECT: key_valid with key_digit<=9 SHALL update acc=acc*10+key_digit and increment digit_count.
REQ-017 Acceptance of digit number NUM_DIGITS SHALL load code=final acc and assert code_valid in the cycle after that edge (latency 1).
REQ-018 Arithmetic SHALL be unsigned 16-bit; max value 9999, no overflow within legal NUM_DIGITS.
REQ-019 key_valid with key_digit>9 in IDLE or COLLECT SHALL pulse key_error for exactly one cycle, clear acc and digit_count, go to IDLE.
REQ-020 key_clear SHALL take priority over same-cycle key_valid: go to IDLE, clear acc/digit_count, drop code_valid, no key_error.
REQ-021 PRESENT: code and code_valid SHALL stay stable until code_ack is sampled high; key_valid SHALL be ignored.
REQ-022 code_ack high in PRESENT SHALL deassert code_valid next cycle and return to IDLE with digit_count=0; code keeps last value.
REQ-023 code_ack outside PRESENT SHALL be ignored.
REQ-024 code_ack and key_clear simultaneous in PRESENT SHALL both yield IDLE, no error.

Reset
REQ-025 rst low SHALL immediately force IDLE, code=0, code_valid=0, busy=0, digit_count=0, key_error=0, acc=0, timeout counter=0.
REQ-026 Reset asserted mid-entry or in PRESENT SHALL discard the entry; first edge after release behaves as IDLE.

Configuration
REQ-027 Macro KEYPAD_TIMEOUT_EN defined: in COLLECT a counter SHALL clear on each accepted digit and increment each cycle without key_valid; reaching TIMEOUT_CYCLES SHALL pulse key_error and return to IDLE with acc cleared.
REQ-028 Macro KEYPAD_TIMEOUT_EN undefined: no timeout logic SHALL exist; COLLECT waits indefinitely; TIMEOUT_CYCLES unused.
REQ-029 Timeout SHALL never apply in IDLE or PRESENT.

Verification
REQ-030 Reset, enter 5,9,9,0 on consecutive key_valid -> code=5990 (0x1766), code_valid=1 one cycle after digit 0, held until code_ack, low next cycle, busy=0.
REQ-031 Enter 1,2 then key_digit=0xA -> key_error high exactly one cycle, digit_count=0, state IDLE, code_valid stays 0.
REQ-032 Enter 3,4 then key_clear with key_valid (digit 7) same cycle -> IDLE, digit_count=0, no key_error, 7 not accepted.
REQ-033 In PRESENT with code=5990 apply key_valid digits 1,1 -> code remains 5990, digit_count remains 4, code_valid remains 1.
REQ-034 TIMEOUT_CYCLES=8, one digit then 8 idle cycles -> with KEYPAD_TIMEOUT_EN key_error pulse and IDLE; without, state COLLECT, digit_count=1.
REQ-035 Assert rst low mid-cycle after 3 digits -> all outputs 0 without waiting for clk edge; fresh 5,9,9,0 entry then yields 5990.
